// File: rtl/mem_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// mem_store_buffer_pkg : shared types and defaults for the store buffer
// Revision: 1.0
// ============================================================================
package mem_store_buffer_pkg;

  localparam int unsigned SB_DEPTH_LOG2_DEFAULT = 2;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  sel;
    logic [31:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_LOAD  = 2'd1,
    PORT_DRAIN = 2'd2
  } port_owner_e;

endpackage
`default_nettype wire

// File: rtl/store_buf_fifo.sv
`default_nettype none
// ============================================================================
// store_buf_fifo : circular entry storage with push/pop and parallel word hit
// Revision: 1.0
// ============================================================================
module store_buf_fifo
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = SB_DEPTH_LOG2_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  sb_entry_t                  push_entry_i,
  input  logic                       pop_i,
  input  logic [29:0]                lookup_waddr_i,
  output sb_entry_t                  head_entry_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [(1<<DEPTH_LOG2)-1:0] hit_vec_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  // A single-entry buffer still needs a one-bit pointer to index storage.
  localparam int unsigned PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;

  sb_entry_t              mem_q [DEPTH];
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    if (push_i) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = ptr_inc(tail_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit_vec_o[i] = valid_q[i] && (mem_q[i].waddr == lookup_waddr_i);
  end

  assign head_entry_o = mem_q[head_q];
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================================
// mem_store_buffer : posted-write buffer arbitrating the data_ram port
// Revision: 1.0
// ============================================================================
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = SB_DEPTH_LOG2_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  input  logic        sync_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        sb_empty_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  logic                       w_load;
  logic                       w_store;
  logic                       w_hit;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic [(1<<DEPTH_LOG2)-1:0] w_hit_vec;
  sb_entry_t                  w_head;
  sb_entry_t                  w_push_entry;
  port_owner_e                w_owner;

  assign w_load  = mem_ce_i && !mem_we_i;
  // Stores with no byte lanes are accepted but never reach the RAM.
  assign w_store = mem_ce_i && mem_we_i && (mem_sel_i != 4'b0000);
  assign w_hit   = |w_hit_vec;

  assign w_push_entry = '{waddr: mem_addr_i[31:2], sel: mem_sel_i, data: mem_data_i};

  store_buf_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push_i         (w_push),
    .push_entry_i   (w_push_entry),
    .pop_i          (w_pop),
    .lookup_waddr_i (mem_addr_i[31:2]),
    .head_entry_o   (w_head),
    .full_o         (w_full),
    .empty_o        (w_empty),
    .hit_vec_o      (w_hit_vec)
  );

  always_comb begin
    w_owner    = PORT_IDLE;
    mem_data_o = 32'h0;
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = 32'h0;
    ram_sel_o  = 4'b0000;
    ram_data_o = 32'h0;

    // A clean load owns the port; otherwise any queued store drains.
    if (w_load && !w_hit) begin
      w_owner = PORT_LOAD;
    end else if (!w_empty) begin
      w_owner = PORT_DRAIN;
    end

    case (w_owner)
      PORT_LOAD: begin
        ram_ce_o   = 1'b1;
        ram_addr_o = mem_addr_i;
        ram_sel_o  = mem_sel_i;
        mem_data_o = ram_data_i;
      end
      PORT_DRAIN: begin
        ram_ce_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = {w_head.waddr, 2'b00};
        ram_sel_o  = w_head.sel;
        ram_data_o = w_head.data;
      end
      default: ;
    endcase
  end

  assign w_pop      = (w_owner == PORT_DRAIN);
  assign w_push     = w_store && !w_full;
  assign stallreq_o = (w_load && w_hit) || (w_store && w_full) || (sync_i && !w_empty);
  assign sb_empty_o = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
`default_nettype none
// ============================================================================
// tb_mem_store_buffer : directed checks of the store buffer with a RAM model
// Revision: 1.0
// ============================================================================
module tb_mem_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce, mem_we, sync;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  mem_sel;

  logic [31:0] mem_data_o, ram_addr_o, ram_data_o, ram_data_i;
  logic        stallreq_o, sb_empty_o, ram_ce_o, ram_we_o;
  logic [3:0]  ram_sel_o;

  logic [31:0] d1_mem_data_o, d1_ram_addr_o, d1_ram_data_o;
  logic        d1_stallreq_o, d1_sb_empty_o, d1_ram_ce_o, d1_ram_we_o;
  logic [3:0]  d1_ram_sel_o;

  logic [31:0] ram [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_store_buffer u_dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (mem_ce),
    .mem_we_i   (mem_we),
    .mem_addr_i (mem_addr),
    .mem_sel_i  (mem_sel),
    .mem_data_i (mem_data),
    .sync_i     (sync),
    .mem_data_o (mem_data_o),
    .stallreq_o (stallreq_o),
    .sb_empty_o (sb_empty_o),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_sel_o  (ram_sel_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i)
  );

  // Single-entry instance: the only configuration in which the full path is reachable.
  mem_store_buffer #(.DEPTH_LOG2(0)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (mem_ce),
    .mem_we_i   (mem_we),
    .mem_addr_i (mem_addr),
    .mem_sel_i  (mem_sel),
    .mem_data_i (mem_data),
    .sync_i     (sync),
    .mem_data_o (d1_mem_data_o),
    .stallreq_o (d1_stallreq_o),
    .sb_empty_o (d1_sb_empty_o),
    .ram_ce_o   (d1_ram_ce_o),
    .ram_we_o   (d1_ram_we_o),
    .ram_addr_o (d1_ram_addr_o),
    .ram_sel_o  (d1_ram_sel_o),
    .ram_data_o (d1_ram_data_o),
    .ram_data_i (32'h0)
  );

  assign ram_data_i = ram[ram_addr_o[11:2]];

  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel_o[b]) ram[ram_addr_o[11:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] data, input logic sy);
    mem_ce   = ce;
    mem_we   = we;
    mem_addr = addr;
    mem_sel  = sel;
    mem_data = data;
    sync     = sy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    #2;
    chk("rst_empty",   {31'b0, sb_empty_o}, 32'd1);
    chk("rst_ce",      {31'b0, ram_ce_o},   32'd0);
    chk("rst_stall",   {31'b0, stallreq_o}, 32'd0);
    chk("rst_rdata",   mem_data_o,          32'h0);
    chk("rst_addr",    ram_addr_o,          32'h0);
    chk("rst_d1_empty",{31'b0, d1_sb_empty_o}, 32'd1);
    tick();
    rst = 1'b0;

    // Store then drain, then read back
    drive(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0); #1;
    chk("t1_st_stall", {31'b0, stallreq_o}, 32'd0);
    chk("t1_st_ce",    {31'b0, ram_ce_o},   32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0); #1;
    chk("t1_dr_we",    {31'b0, ram_we_o},   32'd1);
    chk("t1_dr_addr",  ram_addr_o,          32'h100);
    chk("t1_dr_data",  ram_data_o,          32'hDEADBEEF);
    chk("t1_dr_sel",   {28'b0, ram_sel_o},  32'hF);
    chk("t1_dr_nempty",{31'b0, sb_empty_o}, 32'd0);
    tick(); #1;
    chk("t1_empty",    {31'b0, sb_empty_o}, 32'd1);
    drive(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0); #1;
    chk("t1_ld_data",  mem_data_o,          32'hDEADBEEF);
    chk("t1_ld_we",    {31'b0, ram_we_o},   32'd0);
    chk("t1_ld_stall", {31'b0, stallreq_o}, 32'd0);
    tick();

    // RAW hit on a different byte of the same word
    drive(1'b1, 1'b1, 32'h200, 4'h1, 32'h000000AA, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h202, 4'hF, 32'h0, 1'b0); #1;
    chk("t2_hit_stall", {31'b0, stallreq_o}, 32'd1);
    chk("t2_hit_rdata", mem_data_o,          32'h0);
    chk("t2_hit_drain", ram_addr_o,          32'h200);
    tick();
    chk("t2_ld_stall",  {31'b0, stallreq_o}, 32'd0);
    chk("t2_ld_data",   mem_data_o,          32'h000000AA);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    tick();

    // Loads to another word take the port ahead of the queued store
    drive(1'b1, 1'b1, 32'h400, 4'hF, 32'h44444444, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 1'b0); #1;
      chk("t3_ld_stall",  {31'b0, stallreq_o}, 32'd0);
      chk("t3_ld_we",     {31'b0, ram_we_o},   32'd0);
      chk("t3_ld_addr",   ram_addr_o,          32'h300);
      chk("t3_ld_nempty", {31'b0, sb_empty_o}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0); #1;
    chk("t3_dr_we",    {31'b0, ram_we_o}, 32'd1);
    chk("t3_dr_addr",  ram_addr_o,        32'h400);
    tick(); #1;
    chk("t3_empty",    {31'b0, sb_empty_o}, 32'd1);

    // Zero-lane store is a no-op
    drive(1'b1, 1'b1, 32'h480, 4'h0, 32'hFFFFFFFF, 1'b0); #1;
    chk("sel0_stall",  {31'b0, stallreq_o}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0); #1;
    chk("sel0_empty",  {31'b0, sb_empty_o}, 32'd1);
    chk("sel0_ce",     {31'b0, ram_ce_o},   32'd0);
    tick();

    // Full buffer on the single-entry instance
    drive(1'b1, 1'b1, 32'h600, 4'hF, 32'h1, 1'b0); #1;
    chk("t4_a_stall",  {31'b0, d1_stallreq_o}, 32'd0);
    tick();
    drive(1'b1, 1'b1, 32'h604, 4'hF, 32'h2, 1'b0); #1;
    chk("t4_full_stall", {31'b0, d1_stallreq_o}, 32'd1);
    chk("t4_full_we",    {31'b0, d1_ram_we_o},   32'd1);
    chk("t4_full_addr",  d1_ram_addr_o,          32'h600);
    chk("t4_full_data",  d1_ram_data_o,          32'h1);
    tick();
    chk("t4_enq_stall",  {31'b0, d1_stallreq_o}, 32'd0);
    chk("t4_enq_ce",     {31'b0, d1_ram_ce_o},   32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0); #1;
    chk("t4_b_we",       {31'b0, d1_ram_we_o},   32'd1);
    chk("t4_b_addr",     d1_ram_addr_o,          32'h604);
    chk("t4_b_data",     d1_ram_data_o,          32'h2);
    chk("t4_b_sel",      {28'b0, d1_ram_sel_o},  32'hF);
    tick(); #1;
    chk("t4_empty",      {31'b0, sb_empty_o},    32'd1);
    chk("t4_d1_empty",   {31'b0, d1_sb_empty_o}, 32'd1);
    chk("t4_d1_rdata",   d1_mem_data_o,          32'h0);

    // Sync with nothing queued does not stall
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1); #1;
    chk("sync_idle",   {31'b0, stallreq_o}, 32'd0);
    tick();

    // Same-word stores commit oldest first; sync waits for drain
    drive(1'b1, 1'b1, 32'h500, 4'hF, 32'h11111111, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h500, 4'hF, 32'h22222222, 1'b0); #1;
    chk("t5_first",    ram_data_o,          32'h11111111);
    chk("t5_st_stall", {31'b0, stallreq_o}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1); #1;
    chk("t5_sync_stall", {31'b0, stallreq_o}, 32'd1);
    chk("t5_second",     ram_data_o,          32'h22222222);
    tick();
    chk("t5_sync_done",  {31'b0, stallreq_o}, 32'd0);
    chk("t5_empty",      {31'b0, sb_empty_o}, 32'd1);
    drive(1'b1, 1'b0, 32'h500, 4'hF, 32'h0, 1'b0); #1;
    chk("t5_final",      mem_data_o,          32'h22222222);
    tick();

    // Asynchronous reset discards the queued store
    drive(1'b1, 1'b1, 32'h700, 4'hF, 32'h77777777, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0); #1;
    chk("t6_pre_nempty", {31'b0, sb_empty_o}, 32'd0);
    rst = 1'b1; #1;
    chk("t6_empty",  {31'b0, sb_empty_o}, 32'd1);
    chk("t6_ce",     {31'b0, ram_ce_o},   32'd0);
    chk("t6_stall",  {31'b0, stallreq_o}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h700, 4'hF, 32'h0, 1'b0); #1;
    chk("t6_nowrite", mem_data_o, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0); #1;
    chk("t6_idle_ce", {31'b0, ram_ce_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
